// File: rtl/axi_burst_copy_master_if.sv
// AXI4 read/write channel bundle used by the burst copy master.
// The master modport drives AR/AW/W and the R/B readies; the slave modport is the responder view.
interface axi_burst_copy_master_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 128
);
   logic                      arvalid;
   logic                      arready;
   logic [ADDR_WIDTH-1:0]     araddr;
   logic [7:0]                arlen;
   logic [2:0]                arsize;
   logic [1:0]                arburst;

   logic                      rvalid;
   logic [DATA_WIDTH-1:0]     rdata;
   logic                      rlast;
   logic                      rready;

   logic                      awvalid;
   logic                      awready;
   logic [ADDR_WIDTH-1:0]     awaddr;
   logic [7:0]                awlen;
   logic [2:0]                awsize;
   logic [1:0]                awburst;

   logic                      wvalid;
   logic [DATA_WIDTH-1:0]     wdata;
   logic [DATA_WIDTH/8-1:0]   wstrb;
   logic                      wlast;
   logic                      wready;

   logic                      bvalid;
   logic                      bready;

   modport master (
      output arvalid, araddr, arlen, arsize, arburst,
      input  arready,
      input  rvalid, rdata, rlast,
      output rready,
      output awvalid, awaddr, awlen, awsize, awburst,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid,
      output bready
   );

   modport slave (
      input  arvalid, araddr, arlen, arsize, arburst,
      output arready,
      output rvalid, rdata, rlast,
      input  rready,
      input  awvalid, awaddr, awlen, awsize, awburst,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid,
      input  bready
   );
endinterface

// File: rtl/axi_burst_copy_master.sv
// AXI4 DMA copy engine: reads INCR bursts into a one-chunk beat buffer, then writes them back out.
// Chunks never cross a 4 KB page on either side and never exceed the buffer depth.
module axi_burst_copy_master #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 128,
   parameter int MAX_BURST  = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   src_addr,
   input  logic [ADDR_WIDTH-1:0]   dst_addr,
   input  logic [CNT_WIDTH-1:0]    num_beats,
   output logic                    busy,
   output logic                    done,
   axi_burst_copy_master_if.master bus
);
   localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);
   localparam int IDX_WIDTH  = $clog2(MAX_BURST);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_DONE
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   src_q;
   logic [ADDR_WIDTH-1:0]   dst_q;
   logic [CNT_WIDTH-1:0]    rem_q;
   logic [7:0]              len_m1;
   logic [7:0]              ridx;
   logic [7:0]              widx;
   logic [DATA_WIDTH-1:0]   beat_buf [MAX_BURST];

   // Burst length bounded by beats left, buffer depth and the room left in both 4 KB pages.
   function automatic logic [8:0] chunk_len(input logic [CNT_WIDTH-1:0]  rem,
                                            input logic [ADDR_WIDTH-1:0] s,
                                            input logic [ADDR_WIDTH-1:0] d);
      logic [12:0] s_room;
      logic [12:0] d_room;
      logic [12:0] len;
      s_room = (13'h1000 - {1'b0, s[11:0]}) >> BEAT_SHIFT;
      d_room = (13'h1000 - {1'b0, d[11:0]}) >> BEAT_SHIFT;
      len    = 13'(MAX_BURST);
      if (s_room < len) len = s_room;
      if (d_room < len) len = d_room;
      if (32'(rem) < 32'(len)) len = 13'(rem);
      return 9'(len);
   endfunction

   logic [8:0]              start_len;
   logic [8:0]              next_len;
   logic [ADDR_WIDTH-1:0]   chunk_bytes;
   logic [ADDR_WIDTH-1:0]   src_nx;
   logic [ADDR_WIDTH-1:0]   dst_nx;
   logic [CNT_WIDTH-1:0]    rem_nx;
   logic [7:0]              widx_p1;
   logic                    unused_rlast;

   assign chunk_bytes  = ADDR_WIDTH'({1'b0, len_m1} + 9'd1) << BEAT_SHIFT;
   assign src_nx       = src_q + chunk_bytes;
   assign dst_nx       = dst_q + chunk_bytes;
   assign rem_nx       = rem_q - CNT_WIDTH'({1'b0, len_m1} + 9'd1);
   assign start_len    = chunk_len(num_beats, src_addr, dst_addr);
   assign next_len     = chunk_len(rem_nx, src_nx, dst_nx);
   assign widx_p1      = widx + 8'd1;
   // The beat count closes a read burst; rlast is informational only.
   assign unused_rlast = bus.rlast;

   assign bus.arsize  = 3'b100;
   assign bus.arburst = 2'b01;
   assign bus.awsize  = 3'b100;
   assign bus.awburst = 2'b01;
   assign bus.wstrb   = '1;

   // NOTE: the beat buffer has no reset; a chunk is always fully written before it is read,
   // so clearing the indices is enough to empty it and the array stays plain RAM.
   always_ff @(posedge clk) begin
      if (state == S_RD_DATA && bus.rvalid && bus.rready)
         beat_buf[ridx[IDX_WIDTH-1:0]] <= bus.rdata;
   end

   // NOTE: every state and output register below is updated with <= so all of them see
   // pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         src_q       <= '0;
         dst_q       <= '0;
         rem_q       <= '0;
         len_m1      <= '0;
         ridx        <= '0;
         widx        <= '0;
         bus.arvalid <= 1'b0;
         bus.araddr  <= '0;
         bus.arlen   <= '0;
         bus.rready  <= 1'b0;
         bus.awvalid <= 1'b0;
         bus.awaddr  <= '0;
         bus.awlen   <= '0;
         bus.wvalid  <= 1'b0;
         bus.wdata   <= '0;
         bus.wlast   <= 1'b0;
         bus.bready  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  if (num_beats == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     src_q       <= src_addr;
                     dst_q       <= dst_addr;
                     rem_q       <= num_beats;
                     busy        <= 1'b1;
                     len_m1      <= 8'(start_len - 9'd1);
                     bus.araddr  <= src_addr;
                     bus.arlen   <= 8'(start_len - 9'd1);
                     bus.arvalid <= 1'b1;
                     state       <= S_RD_ADDR;
                  end
               end
            end
            S_RD_ADDR: begin
               if (bus.arready) begin
                  bus.arvalid <= 1'b0;
                  bus.rready  <= 1'b1;
                  ridx        <= '0;
                  state       <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (bus.rvalid) begin
                  ridx <= ridx + 8'd1;
                  if (ridx == len_m1) begin
                     bus.rready  <= 1'b0;
                     bus.awaddr  <= dst_q;
                     bus.awlen   <= len_m1;
                     bus.awvalid <= 1'b1;
                     state       <= S_WR_ADDR;
                  end
               end
            end
            S_WR_ADDR: begin
               // W starts only after AW is accepted, so the slave never sees data without an address.
               if (bus.awready) begin
                  bus.awvalid <= 1'b0;
                  bus.wvalid  <= 1'b1;
                  bus.wdata   <= beat_buf[0];
                  bus.wlast   <= (len_m1 == 8'd0);
                  widx        <= '0;
                  state       <= S_WR_DATA;
               end
            end
            S_WR_DATA: begin
               if (bus.wready) begin
                  if (bus.wlast) begin
                     bus.wvalid <= 1'b0;
                     bus.wlast  <= 1'b0;
                     bus.bready <= 1'b1;
                     state      <= S_WR_RESP;
                  end else begin
                     widx      <= widx_p1;
                     bus.wdata <= beat_buf[widx_p1[IDX_WIDTH-1:0]];
                     bus.wlast <= (widx_p1 == len_m1);
                  end
               end
            end
            S_WR_RESP: begin
               if (bus.bvalid) begin
                  bus.bready <= 1'b0;
                  src_q      <= src_nx;
                  dst_q      <= dst_nx;
                  rem_q      <= rem_nx;
                  if (rem_nx == '0) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     len_m1      <= 8'(next_len - 9'd1);
                     bus.araddr  <= src_nx;
                     bus.arlen   <= 8'(next_len - 9'd1);
                     bus.arvalid <= 1'b1;
                     state       <= S_RD_ADDR;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_axi_burst_copy_master.sv
// Self-checking bench: AXI memory responder with optional random stalls, a table of copy commands,
// and hand-written sequences for zero-length, start-while-busy and mid-transfer reset.
module tb_axi_burst_copy_master;
   localparam int AW        = 64;
   localparam int DW        = 128;
   localparam int MB        = 16;
   localparam int CW        = 16;
   localparam int MEM_WORDS = 16384;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] src_addr = '0;
   logic [AW-1:0] dst_addr = '0;
   logic [CW-1:0] num_beats = '0;
   logic          busy;
   logic          done;

   axi_burst_copy_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   axi_burst_copy_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .src_addr  (src_addr),
      .dst_addr  (dst_addr),
      .num_beats (num_beats),
      .busy      (busy),
      .done      (done),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- memory and responder ----------------
   logic [DW-1:0] mem [MEM_WORDS];

   function automatic logic [DW-1:0] pat(input int i);
      return {32'(32'hC0DE_0000 ^ i), 32'(i * 7 + 1), 32'(~i), 32'(i)};
   endfunction

   function automatic int word(input logic [AW-1:0] a, input int beat);
      return (int'(a[17:4]) + beat) % MEM_WORDS;
   endfunction

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    len;
   } burst_t;

   burst_t        ar_q[$];
   burst_t        aw_q[$];
   int            r_beat = 0, w_beat = 0, b_pend = 0;
   bit            r_took = 0, b_took = 0, stall_en = 0;
   int            ar_count = 0, aw_count = 0, done_count = 0, proto_err = 0;
   logic [7:0]    first_arlen = '0, last_arlen = '0;
   logic [AW-1:0] last_araddr = '0;
   bit            prev_rst = 1, prev_arv = 0, prev_awv = 0, prev_wv = 0;
   bit            prev_ar_hs = 0, prev_aw_hs = 0, prev_w_hs = 0;
   logic [AW-1:0] prev_araddr = '0, prev_awaddr = '0;
   logic [7:0]    prev_arlen = '0, prev_awlen = '0;
   logic [DW-1:0] prev_wdata = '0;
   logic          prev_wlast = 0;

   function automatic bit go();
      return !stall_en || ($urandom_range(0, 2) == 0);
   endfunction

   // Responder acts at negedge; the handshakes it predicts are exactly those of the next posedge.
   initial begin : responder
      bit ar_hs, aw_hs, w_hs;
      bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rlast = 0;
      bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
      forever begin
         @(negedge clk);
         if (done) done_count++;
         if (!prev_rst) begin
            if (prev_arv && !prev_ar_hs &&
                !(bus.arvalid && bus.araddr == prev_araddr && bus.arlen == prev_arlen)) proto_err++;
            if (prev_awv && !prev_aw_hs &&
                !(bus.awvalid && bus.awaddr == prev_awaddr && bus.awlen == prev_awlen)) proto_err++;
            if (prev_wv && !prev_w_hs &&
                !(bus.wvalid && bus.wdata == prev_wdata && bus.wlast == prev_wlast)) proto_err++;
         end
         if (rst) begin
            ar_q.delete(); aw_q.delete();
            r_beat = 0; w_beat = 0; b_pend = 0; r_took = 0; b_took = 0;
            bus.arready = 0; bus.rvalid = 0; bus.rlast = 0;
            bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
            prev_rst = 1; prev_arv = 0; prev_awv = 0; prev_wv = 0;
         end else begin
            bus.arready = go();
            bus.awready = go();
            bus.wready  = go();
            if (!(bus.rvalid && !r_took)) begin
               bus.rvalid = (ar_q.size() != 0) && go();
               bus.rlast  = 0;
               if (bus.rvalid) begin
                  bus.rdata = mem[word(ar_q[0].addr, r_beat)];
                  bus.rlast = (r_beat == int'(ar_q[0].len));
               end
            end
            if (!(bus.bvalid && !b_took)) bus.bvalid = (b_pend != 0) && go();

            r_took = bus.rvalid && bus.rready;
            b_took = bus.bvalid && bus.bready;
            ar_hs  = bus.arvalid && bus.arready;
            aw_hs  = bus.awvalid && bus.awready;
            w_hs   = bus.wvalid && bus.wready;

            if (w_hs) begin
               if (aw_q.size() == 0) proto_err++;
               else begin
                  mem[word(aw_q[0].addr, w_beat)] = bus.wdata;
                  if (bus.wlast != (w_beat == int'(aw_q[0].len))) proto_err++;
                  if (bus.wstrb != 16'hFFFF) proto_err++;
                  if (w_beat == int'(aw_q[0].len)) begin
                     void'(aw_q.pop_front()); w_beat = 0; b_pend++;
                  end else w_beat++;
               end
            end
            if (aw_hs) begin
               aw_q.push_back('{bus.awaddr, bus.awlen});
               aw_count++;
               if (bus.awsize != 3'b100 || bus.awburst != 2'b01) proto_err++;
            end
            if (ar_hs) begin
               if (ar_count == 0) first_arlen = bus.arlen;
               last_araddr = bus.araddr;
               last_arlen  = bus.arlen;
               ar_count++;
               ar_q.push_back('{bus.araddr, bus.arlen});
               if (bus.arsize != 3'b100 || bus.arburst != 2'b01) proto_err++;
            end
            if (r_took && ar_q.size() != 0) begin
               if (r_beat == int'(ar_q[0].len)) begin
                  void'(ar_q.pop_front()); r_beat = 0;
               end else r_beat++;
            end
            if (b_took) b_pend--;

            prev_rst = 0;
            prev_arv = bus.arvalid; prev_ar_hs = ar_hs; prev_araddr = bus.araddr; prev_arlen = bus.arlen;
            prev_awv = bus.awvalid; prev_aw_hs = aw_hs; prev_awaddr = bus.awaddr; prev_awlen = bus.awlen;
            prev_wv  = bus.wvalid;  prev_w_hs  = w_hs;  prev_wdata  = bus.wdata;  prev_wlast = bus.wlast;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic clear_stats();
      ar_count = 0; aw_count = 0; done_count = 0; proto_err = 0;
   endtask

   task automatic issue(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [CW-1:0] n);
      @(posedge clk); #1;
      src_addr = s; dst_addr = d; num_beats = n; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int c = 0; c < 4000 && done_count == 0; c++) @(negedge clk);
      repeat (4) @(negedge clk);
   endtask

   typedef struct {
      logic [AW-1:0] src;
      logic [AW-1:0] dst;
      logic [CW-1:0] n;
      bit            stall;
      int            bursts;
      logic [7:0]    first_len;
      logic [AW-1:0] last_addr;
      logic [7:0]    last_len;
   } vec_t;

   vec_t vecs[9];

   initial begin : main
      int errs;
      bit got;
      vecs[0] = '{64'h0000, 64'h00400,  16'd4,  1'b0, 1, 8'd3,  64'h0000, 8'd3};
      vecs[1] = '{64'h0000, 64'h08000,  16'd40, 1'b0, 3, 8'd15, 64'h0200, 8'd7};
      vecs[2] = '{64'h0FC0, 64'h09000,  16'd8,  1'b0, 2, 8'd3,  64'h1000, 8'd3};
      vecs[3] = '{64'h2000, 64'h0AFE0,  16'd5,  1'b0, 2, 8'd1,  64'h2020, 8'd2};
      vecs[4] = '{64'h3000, 64'h0C000,  16'd1,  1'b0, 1, 8'd0,  64'h3000, 8'd0};
      vecs[5] = '{64'h0000, 64'h0D000,  16'd20, 1'b1, 2, 8'd15, 64'h0100, 8'd3};
      vecs[6] = '{64'h4000, 64'h0E000,  16'd17, 1'b1, 2, 8'd15, 64'h4100, 8'd0};
      vecs[7] = '{64'h3800, 64'h0F000,  16'd0,  1'b0, 0, 8'd0,  64'h0000, 8'd0};
      vecs[8] = '{64'h0FC0, 64'h14F80,  16'd40, 1'b1, 4, 8'd3,  64'h1140, 8'd15};

      for (int i = 0; i < MEM_WORDS; i++) mem[i] = pat(i);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctl", 128'({busy, done, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.wlast, bus.bready}), 128'(0));
      check("reset_addr", {bus.araddr, bus.awaddr}, 128'(0));
      check("reset_len", 128'({bus.arlen, bus.awlen}), 128'(0));
      check("consts", 128'({bus.arsize, bus.arburst, bus.awsize, bus.awburst, bus.wstrb}),
            128'({3'b100, 2'b01, 3'b100, 2'b01, 16'hFFFF}));
      @(posedge clk); #1 rst = 1'b0;

      // Table-driven copies
      foreach (vecs[i]) begin
         stall_en = vecs[i].stall;
         clear_stats();
         issue(vecs[i].src, vecs[i].dst, vecs[i].n);
         wait_done();
         check($sformatf("v%0d_done_cnt", i), 128'(done_count), 128'(1));
         check($sformatf("v%0d_ar_cnt", i), 128'(ar_count), 128'(vecs[i].bursts));
         check($sformatf("v%0d_aw_cnt", i), 128'(aw_count), 128'(vecs[i].bursts));
         if (vecs[i].bursts > 0) begin
            check($sformatf("v%0d_first_arlen", i), 128'(first_arlen), 128'(vecs[i].first_len));
            check($sformatf("v%0d_last_araddr", i), 128'(last_araddr), 128'(vecs[i].last_addr));
            check($sformatf("v%0d_last_arlen", i), 128'(last_arlen), 128'(vecs[i].last_len));
         end
         errs = 0;
         for (int j = 0; j < int'(vecs[i].n); j++)
            if (mem[word(vecs[i].dst, j)] !== pat(word(vecs[i].src, j))) errs++;
         check($sformatf("v%0d_data", i), 128'(errs), 128'(0));
         check($sformatf("v%0d_guard", i), mem[word(vecs[i].dst, int'(vecs[i].n))],
               pat(word(vecs[i].dst, int'(vecs[i].n))));
         check($sformatf("v%0d_proto", i), 128'(proto_err), 128'(0));
         check($sformatf("v%0d_idle", i), 128'(busy), 128'(0));
      end
      stall_en = 0;

      // Zero-length command: done the cycle after start, busy stays low
      clear_stats();
      issue(64'h3800, 64'h0F000, 16'd0);
      @(negedge clk);
      check("zero_done_now", 128'({done, busy}), 128'(2'b10));
      @(negedge clk);
      check("zero_done_gone", 128'(done), 128'(0));

      // Start while busy is ignored
      clear_stats();
      issue(64'h6000, 64'h12000, 16'd4);
      @(negedge clk);
      check("busy_next_cycle", 128'(busy), 128'(1));
      issue(64'h7000, 64'h13000, 16'd2);
      wait_done();
      check("ignore_ar_cnt", 128'(ar_count), 128'(1));
      check("ignore_done_cnt", 128'(done_count), 128'(1));
      check("ignore_no_write", mem[word(64'h13000, 0)], pat(word(64'h13000, 0)));
      check("ignore_first_ok", mem[word(64'h12000, 3)], pat(word(64'h6000, 3)));

      // Reset during WR_DATA, then a fresh command
      clear_stats();
      issue(64'h5000, 64'h10000, 16'd8);
      got = 0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         got = bus.wvalid;
      end
      check("rst_reached_wdata", 128'(got), 128'(1));
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_outputs", 128'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, busy, done}), 128'(0));
      @(posedge clk); #1 rst = 1'b0;
      clear_stats();
      repeat (10) @(negedge clk);
      check("rst_quiet", 128'({ar_count, aw_count, done_count}), 128'(0));
      issue(64'h5000, 64'h11000, 16'd8);
      wait_done();
      check("rst_recover_done", 128'(done_count), 128'(1));
      errs = 0;
      for (int j = 0; j < 8; j++)
         if (mem[word(64'h11000, j)] !== pat(word(64'h5000, j))) errs++;
      check("rst_recover_data", 128'(errs), 128'(0));
      check("rst_recover_proto", 128'(proto_err), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin : watchdog
      #900_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
